// File: rtl/calc_keys_pkg.sv
// Shared keypad definitions for the calculator input path.
//   - default code points for the blank, sign and decimal-point keys
//   - key class enum produced by key_classifier
//   - state enum of the digit entry buffer
package calc_keys_pkg;

  localparam int unsigned DEF_BLANK     = 15;
  localparam int unsigned DEF_SIGN_CODE = 14;
  localparam int unsigned DEF_DP_CODE   = 13;
  localparam int unsigned DIGIT_MAX     = 9;

  typedef enum logic [1:0] {
    KEY_DIGIT,
    KEY_SIGN,
    KEY_DP,
    KEY_INVALID
  } key_class_e;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL,
    LOADED
  } state_e;

endpackage

// File: rtl/digit_entry_buffer_if.sv
// Request/status bundle between the keypad decoder and the digit entry buffer.
//   master : keypad side, drives key/backspace/clear/load requests
//   slave  : buffer side, drives display contents and status
interface digit_entry_buffer_if #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned CW = $clog2(COUNT + 1);

  logic                     key_valid;
  logic [WIDTH-1:0]         key_code;
  logic                     backspace;
  logic                     clear;
  logic                     load;
  logic [COUNT*WIDTH-1:0]   load_data;
  logic [COUNT*WIDTH-1:0]   out;
  logic [CW-1:0]            digit_count;
  logic                     has_sign;
  logic                     has_dp;
  logic                     full;
  logic                     reject;

  modport master (
    output key_valid, key_code, backspace, clear, load, load_data,
    input  out, digit_count, has_sign, has_dp, full, reject
  );

  modport slave (
    input  key_valid, key_code, backspace, clear, load, load_data,
    output out, digit_count, has_sign, has_dp, full, reject
  );
endinterface

// File: rtl/key_classifier.sv
// Combinational key classifier, shared with the keypad decoder.
//   key_code_i  : raw key code
//   key_class_o : digit 0-9, sign, decimal point or invalid
module key_classifier
  import calc_keys_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] SIGN_CODE = WIDTH'(DEF_SIGN_CODE),
  parameter logic [WIDTH-1:0] DP_CODE   = WIDTH'(DEF_DP_CODE)
) (
  input  logic [WIDTH-1:0] key_code_i,
  output key_class_e       key_class_o
);

  always_comb begin
    key_class_o = KEY_INVALID;
    if (key_code_i <= WIDTH'(DIGIT_MAX)) key_class_o = KEY_DIGIT;
    else if (key_code_i == SIGN_CODE)    key_class_o = KEY_SIGN;
    else if (key_code_i == DP_CODE)      key_class_o = KEY_DP;
  end

endmodule

// File: rtl/digit_entry_buffer.sv
// Operand entry buffer: collects keypad codes into COUNT display slots,
// newest entry in slot 0. Supports backspace, clear and parallel load of a
// result for display.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : requests in (key/backspace/clear/load), display + status out
//
// state  | meaning
// EMPTY  | no entries, display all blank
// ENTRY  | 1..COUNT-1 entries typed
// FULL   | COUNT entries typed, further pushes rejected
// LOADED | showing a loaded result; next key starts a fresh operand
module digit_entry_buffer
  import calc_keys_pkg::*;
#(
  parameter int unsigned      COUNT     = 4,
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] BLANK     = WIDTH'(DEF_BLANK),
  parameter logic [WIDTH-1:0] SIGN_CODE = WIDTH'(DEF_SIGN_CODE),
  parameter logic [WIDTH-1:0] DP_CODE   = WIDTH'(DEF_DP_CODE)
) (
  input logic                 clk,
  input logic                 reset,
  digit_entry_buffer_if.slave bus
);

  localparam int unsigned            CW        = $clog2(COUNT + 1);
  localparam logic [CW-1:0]          COUNT_C   = CW'(COUNT);
  localparam logic [COUNT*WIDTH-1:0] ALL_BLANK = {COUNT{BLANK}};

  logic [COUNT*WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sign_q, sign_d;
  logic                   dp_q, dp_d;
  logic                   rej_q, rej_d;
  state_e                 state_q, state_d;

  key_class_e             kclass;
  logic [COUNT*WIDTH-1:0] base_out;
  logic [CW-1:0]          base_cnt;
  logic                   base_sign, base_dp;
  logic                   accept, replace;

  key_classifier #(
    .WIDTH     (WIDTH),
    .SIGN_CODE (SIGN_CODE),
    .DP_CODE   (DP_CODE)
  ) u_classifier (
    .key_code_i  (bus.key_code),
    .key_class_o (kclass)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= ALL_BLANK;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      dp_q    <= 1'b0;
      rej_q   <= 1'b0;
      state_q <= EMPTY;
    end else begin
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dp_q    <= dp_d;
      rej_q   <= rej_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    out_d   = out_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dp_d    = dp_q;
    rej_d   = 1'b0;
    state_d = state_q;
    accept  = 1'b0;
    replace = 1'b0;

    // A loaded result is display-only: a key starts from an empty buffer.
    if (state_q == LOADED) begin
      base_out  = ALL_BLANK;
      base_cnt  = '0;
      base_sign = 1'b0;
      base_dp   = 1'b0;
    end else begin
      base_out  = out_q;
      base_cnt  = cnt_q;
      base_sign = sign_q;
      base_dp   = dp_q;
    end

    if (bus.clear) begin
      out_d   = ALL_BLANK;
      cnt_d   = '0;
      sign_d  = 1'b0;
      dp_d    = 1'b0;
      state_d = EMPTY;
    end else if (bus.load) begin
      out_d   = bus.load_data;
      cnt_d   = COUNT_C;
      sign_d  = 1'b0;
      dp_d    = 1'b0;
      state_d = LOADED;
    end else if (bus.backspace) begin
      if (state_q == LOADED) begin
        out_d   = ALL_BLANK;
        cnt_d   = '0;
        sign_d  = 1'b0;
        dp_d    = 1'b0;
        state_d = EMPTY;
      end else if (state_q == EMPTY || cnt_q == '0) begin
        rej_d = 1'b1;
      end else begin
        out_d = {BLANK, out_q[COUNT*WIDTH-1:WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (out_q[WIDTH-1:0] == SIGN_CODE) sign_d = 1'b0;
        if (out_q[WIDTH-1:0] == DP_CODE)   dp_d   = 1'b0;
        state_d = (cnt_q == CW'(1)) ? EMPTY : ENTRY;
      end
    end else if (bus.key_valid) begin
      unique case (kclass)
        KEY_DIGIT: begin
          // A lone leading zero is overwritten rather than shifted left.
          if (base_cnt == CW'(1) && base_out[WIDTH-1:0] == '0) replace = 1'b1;
          else if (base_cnt < COUNT_C)                         accept  = 1'b1;
        end
        KEY_SIGN: accept = (base_cnt == '0);
        KEY_DP:   accept = !base_dp && (base_cnt < COUNT_C);
        default:  accept = 1'b0;
      endcase

      if (replace) begin
        out_d   = {base_out[COUNT*WIDTH-1:WIDTH], bus.key_code};
        cnt_d   = base_cnt;
        sign_d  = base_sign;
        dp_d    = base_dp;
        state_d = ENTRY;
      end else if (accept) begin
        out_d   = {base_out[(COUNT-1)*WIDTH-1:0], bus.key_code};
        cnt_d   = base_cnt + CW'(1);
        sign_d  = base_sign | (kclass == KEY_SIGN);
        dp_d    = base_dp | (kclass == KEY_DP);
        state_d = (cnt_d == COUNT_C) ? FULL : ENTRY;
      end else begin
        rej_d = 1'b1;
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.digit_count = cnt_q;
  assign bus.has_sign    = sign_q;
  assign bus.has_dp      = dp_q;
  assign bus.reject      = rej_q;
  assign bus.full        = (cnt_q == COUNT_C);

endmodule

// File: tb/tb_digit_entry_buffer.sv
module tb_digit_entry_buffer;
  import calc_keys_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  digit_entry_buffer_if #(.COUNT(4), .WIDTH(4)) bus ();

  digit_entry_buffer #(.COUNT(4), .WIDTH(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.backspace = 1'b0;
    bus.clear     = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_key(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    step();
  endtask

  task automatic do_bs();
    @(negedge clk);
    bus.backspace = 1'b1;
    step();
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    step();
  endtask

  task automatic do_load(input logic [15:0] data);
    @(negedge clk);
    bus.load      = 1'b1;
    bus.load_data = data;
    step();
  endtask

  task automatic do_idle();
    @(negedge clk);
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.out !== 16'hFFFF) begin n_err++; $display("FAIL reset_out got=%h exp=%h", bus.out, 16'hFFFF); end
    n_cmp++; if (bus.digit_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.digit_count); end
    n_cmp++; if ({bus.has_sign, bus.has_dp, bus.reject, bus.full} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {bus.has_sign, bus.has_dp, bus.reject, bus.full}); end
    n_cmp++; if (dut.state_q !== EMPTY) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, EMPTY); end
  endtask

  task automatic test_fill();
    do_key(4'h1); do_key(4'h2); do_key(4'h3);
    n_cmp++; if (bus.out !== 16'hF123) begin n_err++; $display("FAIL fill3_out got=%h exp=%h", bus.out, 16'hF123); end
    n_cmp++; if (bus.digit_count !== 3'd3 || bus.full !== 1'b0) begin n_err++; $display("FAIL fill3_count got=%0d/%b exp=3/0", bus.digit_count, bus.full); end
    do_key(4'h4);
    n_cmp++; if (bus.out !== 16'h1234 || bus.full !== 1'b1) begin n_err++; $display("FAIL fill4 got=%h/%b exp=1234/1", bus.out, bus.full); end
    n_cmp++; if (bus.digit_count !== 3'd4 || dut.state_q !== FULL) begin n_err++; $display("FAIL fill4_state got=%0d/%0d exp=4/%0d", bus.digit_count, dut.state_q, FULL); end
    do_key(4'h5);
    n_cmp++; if (bus.reject !== 1'b1 || bus.out !== 16'h1234) begin n_err++; $display("FAIL full_reject got=%b/%h exp=1/1234", bus.reject, bus.out); end
    do_idle();
    n_cmp++; if (bus.reject !== 1'b0) begin n_err++; $display("FAIL reject_pulse got=%b exp=0", bus.reject); end
    do_bs();
    n_cmp++; if (bus.out !== 16'hF123 || dut.state_q !== ENTRY || bus.reject !== 1'b0) begin n_err++; $display("FAIL full_bs got=%h/%0d/%b exp=F123/%0d/0", bus.out, dut.state_q, bus.reject, ENTRY); end
  endtask

  task automatic test_leading_zero();
    do_clear();
    do_key(4'h0);
    n_cmp++; if (bus.out !== 16'hFFF0 || bus.digit_count !== 3'd1) begin n_err++; $display("FAIL lz_first got=%h/%0d exp=FFF0/1", bus.out, bus.digit_count); end
    do_key(4'h0);
    n_cmp++; if (bus.out !== 16'hFFF0 || bus.digit_count !== 3'd1 || bus.reject !== 1'b0) begin n_err++; $display("FAIL lz_second got=%h/%0d/%b exp=FFF0/1/0", bus.out, bus.digit_count, bus.reject); end
    do_key(4'h5);
    n_cmp++; if (bus.out !== 16'hFFF5 || bus.digit_count !== 3'd1) begin n_err++; $display("FAIL lz_replace got=%h/%0d exp=FFF5/1", bus.out, bus.digit_count); end
  endtask

  task automatic test_sign_dp();
    do_clear();
    do_key(4'hE); do_key(4'h3); do_key(4'hD); do_key(4'h4);
    n_cmp++; if (bus.out !== 16'hE3D4 || bus.has_sign !== 1'b1 || bus.has_dp !== 1'b1) begin n_err++; $display("FAIL sdp_fill got=%h/%b%b exp=E3D4/11", bus.out, bus.has_sign, bus.has_dp); end
    do_bs();
    n_cmp++; if (bus.out !== 16'hFE3D || bus.has_dp !== 1'b1 || bus.digit_count !== 3'd3) begin n_err++; $display("FAIL sdp_bs1 got=%h/%b/%0d exp=FE3D/1/3", bus.out, bus.has_dp, bus.digit_count); end
    do_bs();
    n_cmp++; if (bus.out !== 16'hFFE3 || bus.has_dp !== 1'b0 || bus.has_sign !== 1'b1) begin n_err++; $display("FAIL sdp_bs2 got=%h/%b%b exp=FFE3/10", bus.out, bus.has_sign, bus.has_dp); end
    do_bs(); do_bs();
    n_cmp++; if (bus.out !== 16'hFFFF || bus.has_sign !== 1'b0 || dut.state_q !== EMPTY) begin n_err++; $display("FAIL sdp_empty got=%h/%b/%0d exp=FFFF/0/%0d", bus.out, bus.has_sign, dut.state_q, EMPTY); end
    do_bs();
    n_cmp++; if (bus.reject !== 1'b1 || bus.digit_count !== 3'd0) begin n_err++; $display("FAIL bs_empty got=%b/%0d exp=1/0", bus.reject, bus.digit_count); end
  endtask

  task automatic test_rejects();
    do_clear();
    do_key(4'h3); do_key(4'hE);
    n_cmp++; if (bus.reject !== 1'b1 || bus.out !== 16'hFFF3 || bus.has_sign !== 1'b0) begin n_err++; $display("FAIL late_sign got=%b/%h/%b exp=1/FFF3/0", bus.reject, bus.out, bus.has_sign); end
    do_key(4'hF);
    n_cmp++; if (bus.reject !== 1'b1 || bus.digit_count !== 3'd1) begin n_err++; $display("FAIL blank_key got=%b/%0d exp=1/1", bus.reject, bus.digit_count); end
    do_clear();
    do_key(4'hD); do_key(4'hD);
    n_cmp++; if (bus.reject !== 1'b1 || bus.has_dp !== 1'b1 || bus.out !== 16'hFFFD || bus.digit_count !== 3'd1) begin n_err++; $display("FAIL second_dp got=%b/%b/%h/%0d exp=1/1/FFFD/1", bus.reject, bus.has_dp, bus.out, bus.digit_count); end
  endtask

  task automatic test_load();
    do_load(16'h0042);
    n_cmp++; if (bus.out !== 16'h0042 || bus.digit_count !== 3'd4 || bus.full !== 1'b1 || bus.has_dp !== 1'b0) begin n_err++; $display("FAIL load got=%h/%0d/%b/%b exp=0042/4/1/0", bus.out, bus.digit_count, bus.full, bus.has_dp); end
    n_cmp++; if (dut.state_q !== LOADED) begin n_err++; $display("FAIL load_state got=%0d exp=%0d", dut.state_q, LOADED); end
    do_key(4'h9);
    n_cmp++; if (bus.out !== 16'hFFF9 || bus.digit_count !== 3'd1 || dut.state_q !== ENTRY) begin n_err++; $display("FAIL load_key got=%h/%0d/%0d exp=FFF9/1/%0d", bus.out, bus.digit_count, dut.state_q, ENTRY); end
    do_load(16'h0042);
    do_bs();
    n_cmp++; if (bus.out !== 16'hFFFF || bus.digit_count !== 3'd0 || bus.reject !== 1'b0 || dut.state_q !== EMPTY) begin n_err++; $display("FAIL load_bs got=%h/%0d/%b/%0d exp=FFFF/0/0/%0d", bus.out, bus.digit_count, bus.reject, dut.state_q, EMPTY); end
    do_load(16'h1234);
    do_key(4'hE);
    n_cmp++; if (bus.out !== 16'hFFFE || bus.has_sign !== 1'b1 || bus.digit_count !== 3'd1) begin n_err++; $display("FAIL load_sign got=%h/%b/%0d exp=FFFE/1/1", bus.out, bus.has_sign, bus.digit_count); end
  endtask

  task automatic test_priority();
    do_clear();
    do_key(4'h1); do_key(4'h2);
    @(negedge clk);
    bus.clear = 1'b1; bus.key_valid = 1'b1; bus.key_code = 4'h7;
    step();
    n_cmp++; if (bus.out !== 16'hFFFF || bus.digit_count !== 3'd0 || bus.reject !== 1'b0) begin n_err++; $display("FAIL clear_vs_key got=%h/%0d/%b exp=FFFF/0/0", bus.out, bus.digit_count, bus.reject); end
    @(negedge clk);
    bus.load = 1'b1; bus.load_data = 16'h5678; bus.backspace = 1'b1; bus.key_valid = 1'b1; bus.key_code = 4'h3;
    step();
    n_cmp++; if (bus.out !== 16'h5678 || dut.state_q !== LOADED || bus.reject !== 1'b0) begin n_err++; $display("FAIL load_vs_bs got=%h/%0d/%b exp=5678/%0d/0", bus.out, dut.state_q, bus.reject, LOADED); end
  endtask

  task automatic test_async_reset();
    do_clear();
    do_key(4'h6); do_key(4'h7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out !== 16'hFFFF || bus.digit_count !== 3'd0 || dut.state_q !== EMPTY) begin n_err++; $display("FAIL async_reset got=%h/%0d/%0d exp=FFFF/0/%0d", bus.out, bus.digit_count, dut.state_q, EMPTY); end
    #1 rst_n = 1'b1;
    do_key(4'h8);
    n_cmp++; if (bus.out !== 16'hFFF8 || bus.digit_count !== 3'd1) begin n_err++; $display("FAIL after_reset got=%h/%0d exp=FFF8/1", bus.out, bus.digit_count); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_leading_zero();
    test_sign_dp();
    test_rejects();
    test_load();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
